nested_countern: RTL
====================

Name: nested_countern

Overview:
- Parametrised successor of the single-level wrap counter.
- LEVELS cascaded counter levels with independent, runtime-loadable max values. Level 0 is innermost; each outer level advances when every inner level wraps.
- Drives nested-loop indexing in the sponge datapath, e.g. lane/word index inside block index inside round index.
- Per-level start/last/end flags plus a whole-sequence completion indication.

Parameters:
- LEVELS, 2, number of cascaded levels (>=1).
- WIDTH, 8, bits per level counter and per level max (>=1).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- clr  in  1  synchronous clear of all counters and done; max values kept.
- en  in  1  advance the counter chain by one step.
- load_max  in  LEVELS  per-level max load strobe.
- max_count  in  LEVELS*WIDTH  packed max values; level i in bits [i*WIDTH +: WIDTH].
- counter  out  LEVELS*WIDTH  packed current counts, same packing.
- count_start  out  LEVELS  level i counter == 0.
- count_last  out  LEVELS  level i counter == max_i-1; forced 0 when max_i == 0.
- count_end  out  LEVELS  level i counter >= max_i.
- all_end  out  1  AND of all count_end bits.
- done  out  1  sequence completion; behaviour set by the optional feature.

Behaviour:
- Reset (rst_n low, async): all counters 0; all max_i all-ones; done 0. Outputs therefore reset to: count_start all 1, count_end all 0, count_last all 0 (WIDTH>1), all_end 0.
- Priority per edge: clr > any load_max bit > en.
  - clr: counters <= 0 and done <= 0; max values unchanged; load_max and en ignored that cycle.
  - Any load_max bit set: each strobed level captures its max_count slice; non-strobed levels keep their max. No level counts that cycle, even with en=1. A new max affects flags from the next cycle only.
- Counting, when en=1 and no clr/load:
  - tick_0 = 1; tick_i = AND of count_end_j for all j<i.
  - A level with tick set does: counter_i <= (counter_i >= max_i) ? 0 : counter_i+1.
  - A level without tick holds.
- Wrap-around: comparison is >=, not ==. A counter left above a newly loaded smaller max wraps to 0 on its next tick and propagates carry.
- max_i == 0: level i stays at 0, count_end_i is constantly 1, and it passes carry to the next level on every tick.
- All arithmetic is unsigned, WIDTH bits. counter_i+1 cannot overflow because a level at all-ones always satisfies >= max.
- Full wrap: en with all_end=1 (no clr/load) returns every level to 0 in one edge, unless the optional feature is enabled.
- Flags count_start, count_last, count_end, all_end are combinational from registered state only; no input-to-output paths.
- Reset asserted mid-sequence returns immediately to the reset state. Counting resumes from 0 on the first en after rst_n deasserts, with max values back at all-ones.

Optional Feature:
Macro NESTED_COUNTERN_SAT_EN.
- Without the macro (wrap mode):
  - done is a registered 1-cycle pulse, high in the cycle after a full wrap edge.
  - done is 0 in all other cycles.
- With the macro (saturate mode):
  - An en while all_end=1 (no clr/load) does not wrap; all counters hold.
  - done is set on that edge and stays high (sticky) while counters stay frozen.
  - Only clr, a load_max, or reset clears done; any load_max bit also clears done.
  - Further en cycles have no effect while done=1.

Test Plan (LEVELS=2, WIDTH=4):
- Reset: pulse rst_n low mid-count -> counter=0x00 immediately; count_start=2'b11; count_end=2'b00; all_end=0; done=0; max=15/15.
- Load max L1=2, L0=3, then en for 12 cycles -> L0 follows 0,1,2,3,0,...; L1 increments on each L0=3 edge; state {2,3} after 11 ens; after the 12th, counter={0,0}. Wrap mode: done=1 for exactly one cycle after that edge.
- load_max=2'b01 with en=1 and counter={1,2} -> counter stays {1,2}; new L0 max visible in next-cycle flags.
- max L0=0, L1=5 -> L0 stays 0; count_last[0]=0; count_end[0]=1; L1 increments on every en.
- Counter L0=5, load L0 max=3 -> count_end[0]=1 immediately after the load; next en sets L0=0 and L1 increments by 1.
- NESTED_COUNTERN_SAT_EN with max {2,3}: reach {2,3}, then apply 3 more en -> counter holds {2,3}; done=1 sticky; clr -> counter={0,0}, done=0.

Source files
------------

// File: rtl/nested_countern.sv
// Cascaded multi-level loop counter with runtime-loadable per-level max values.
// Define NESTED_COUNTERN_SAT_EN to freeze at the final state with a sticky done.
module nested_countern #(
    parameter int LEVELS = 2,
    parameter int WIDTH  = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clr,
    input  logic                    en,
    input  logic [LEVELS-1:0]       load_max,
    input  logic [LEVELS*WIDTH-1:0] max_count,
    output logic [LEVELS*WIDTH-1:0] counter,
    output logic [LEVELS-1:0]       count_start,
    output logic [LEVELS-1:0]       count_last,
    output logic [LEVELS-1:0]       count_end,
    output logic                    all_end,
    output logic                    done
);

    logic [WIDTH-1:0] cnt_q [LEVELS];
    logic [WIDTH-1:0] cnt_d [LEVELS];
    logic [WIDTH-1:0] max_q [LEVELS];
    logic [WIDTH-1:0] max_d [LEVELS];
    logic             done_q;
    logic             done_d;
    logic             carry;

    always_comb begin
        for (int i = 0; i < LEVELS; i++) begin
            counter[i*WIDTH +: WIDTH] = cnt_q[i];
            count_start[i] = (cnt_q[i] == '0);
            count_end[i]   = (cnt_q[i] >= max_q[i]);
            count_last[i]  = (max_q[i] != '0) &&
                             (cnt_q[i] == max_q[i] - WIDTH'(1));
        end
    end

    assign all_end = &count_end;
    assign done    = done_q;

    always_comb begin
        cnt_d  = cnt_q;
        max_d  = max_q;
        done_d = 1'b0;
        carry  = 1'b1;
        if (clr) begin
            for (int i = 0; i < LEVELS; i++) cnt_d[i] = '0;
        end else if (|load_max) begin
            for (int i = 0; i < LEVELS; i++) begin
                if (load_max[i]) max_d[i] = max_count[i*WIDTH +: WIDTH];
            end
        end else begin
`ifdef NESTED_COUNTERN_SAT_EN
            done_d = done_q;
            if (en && all_end) begin
                done_d = 1'b1;
            end else if (en) begin
`else
            done_d = en & all_end;
            if (en) begin
`endif
                // Each level ticks only when every inner level sits at its end.
                for (int i = 0; i < LEVELS; i++) begin
                    if (carry) cnt_d[i] = count_end[i] ? '0 : cnt_q[i] + WIDTH'(1);
                    carry = carry & count_end[i];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LEVELS; i++) begin
                cnt_q[i] <= '0;
                max_q[i] <= '1;
            end
            done_q <= 1'b0;
        end else begin
            for (int i = 0; i < LEVELS; i++) begin
                cnt_q[i] <= cnt_d[i];
                max_q[i] <= max_d[i];
            end
            done_q <= done_d;
        end
    end

endmodule
